// File: rtl/seg7_card_reader_pkg.sv
// Shared definitions for the 7-segment card reader: segment glyphs (abcdefg, a = MSB),
// decoded digit codes and the capture FSM state encoding.
package seg7_card_reader_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_INV   = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_card_reader_decoder.sv
// Combinational glyph decoder: one 7-segment pattern to BCD, blank to DIG_BLANK,
// anything unrecognised to DIG_INV.
module seg7_decoder
  import seg7_card_reader_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] code
);

  always_comb begin
    code = DIG_INV;
    case (glyph)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = DIG_BLANK;
      default:   code = DIG_INV;
    endcase
  end

endmodule

// File: rtl/seg7_card_reader.sv
// Receive side of the three-digit card-number display: debounces the segment lines until
// stable for STABLE_CYCLES clocks, then reports the decoded digits with a one-cycle valid.
module seg7_card_reader
  import seg7_card_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [20:0]      seg_in,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] capture_cnt
);

  localparam logic [7:0]       STABLE_Q = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CAP_ONE  = CNT_W'(1);

  state_t      state, state_next;
  logic [20:0] samp_q, cand_q, cap_q, cand_next;
  logic [7:0]  cnt, cnt_next;
  logic        enter_report;
  logic [3:0]  dec1, dec2, dec3;

  seg7_decoder u_dec1 (.glyph(cand_q[20:14]), .code(dec1));
  seg7_decoder u_dec2 (.glyph(cand_q[13:7]),  .code(dec2));
  seg7_decoder u_dec3 (.glyph(cand_q[6:0]),   .code(dec3));

  // cand_q tracks the pattern being qualified; a return to the last reported
  // pattern (cap_q) during settling is a glitch and abandons the attempt.
  always_comb begin
    state_next   = state;
    cand_next    = cand_q;
    cnt_next     = cnt;
    enter_report = 1'b0;
    case (state)
      IDLE: begin
        if (samp_q != cap_q) begin
          state_next = SETTLE;
          cand_next  = samp_q;
          cnt_next   = 8'd1;
        end
      end
      SETTLE: begin
        if (samp_q != cand_q) begin
          if (samp_q == cap_q) begin
            state_next = IDLE;
          end else begin
            cand_next = samp_q;
            cnt_next  = 8'd1;
          end
        end else if (cnt == STABLE_Q) begin
          state_next   = REPORT;
          enter_report = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      samp_q      <= '0;
      cand_q      <= '0;
      cap_q       <= '0;
      cnt         <= '0;
      digit1      <= DIG_BLANK;
      digit2      <= DIG_BLANK;
      digit3      <= DIG_BLANK;
      valid       <= 1'b0;
      err         <= 1'b0;
      capture_cnt <= '0;
    end else begin
      samp_q <= seg_in;
      state  <= state_next;
      cand_q <= cand_next;
      cnt    <= cnt_next;
      valid  <= enter_report;
      // Outputs are captured on the edge that enters REPORT and hold until the next one.
      if (enter_report) begin
        cap_q       <= cand_q;
        digit1      <= dec1;
        digit2      <= dec2;
        digit3      <= dec3;
        err         <= (dec1 == DIG_INV) || (dec2 == DIG_INV) || (dec3 == DIG_INV);
        capture_cnt <= capture_cnt + CAP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_seg7_card_reader.sv
// Directed self-checking bench for seg7_card_reader with STABLE_CYCLES = 4.
module tb_seg7_card_reader;
  import seg7_card_reader_pkg::*;

  logic        clock;
  logic        reset;
  logic [20:0] seg_in;
  logic [3:0]  digit1, digit2, digit3;
  logic        valid, err;
  logic [7:0]  capture_cnt;

  int checks = 0;
  int errors = 0;

  seg7_card_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .seg_in(seg_in),
    .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .valid(valid), .err(err), .capture_cnt(capture_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, sampling 1ns after each; records valid pulses by edge index.
  task automatic run_cycles(input int n, output int pulses, output int first, output int last);
    pulses = 0; first = 0; last = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      #1;
      if (valid === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
        last = i;
      end
    end
  endtask

  task automatic test_reset();
    int p, f, l;
    reset = 1'b1; seg_in = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (capture_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", capture_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    reset = 1'b0;
    run_cycles(20, p, f, l);
    checks++; if (p !== 0) begin errors++; $display("[TB] FAIL idle_pulses: got %0d expected 0", p); end
    checks++; if ({digit1, digit2, digit3} !== 12'hFFF) begin errors++; $display("[TB] FAIL idle_digits: got %h expected fff", {digit1, digit2, digit3}); end
    checks++; if (capture_cnt !== 8'd0) begin errors++; $display("[TB] FAIL idle_cnt: got %0d expected 0", capture_cnt); end
  endtask

  task automatic test_basic();
    int p, f, l;
    seg_in = {SEG_3, SEG_0, SEG_8};
    run_cycles(10, p, f, l);
    checks++; if (p !== 1) begin errors++; $display("[TB] FAIL basic_pulses: got %0d expected 1", p); end
    checks++; if (f !== 6) begin errors++; $display("[TB] FAIL basic_latency: got edge %0d expected 6", f); end
    checks++; if ({digit1, digit2, digit3} !== 12'h308) begin errors++; $display("[TB] FAIL basic_digits: got %h expected 308", {digit1, digit2, digit3}); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", err); end
    checks++; if (capture_cnt !== 8'd1) begin errors++; $display("[TB] FAIL basic_cnt: got %0d expected 1", capture_cnt); end
  endtask

  task automatic test_restart();
    int p, f, l;
    seg_in = {SEG_5, SEG_5, SEG_5};
    run_cycles(3, p, f, l);
    checks++; if (p !== 0) begin errors++; $display("[TB] FAIL restart_early: got %0d pulses expected 0", p); end
    seg_in = {SEG_1, SEG_9, SEG_7};
    run_cycles(15, p, f, l);
    checks++; if (p !== 1) begin errors++; $display("[TB] FAIL restart_pulses: got %0d expected 1", p); end
    checks++; if (f !== 6) begin errors++; $display("[TB] FAIL restart_latency: got edge %0d expected 6", f); end
    checks++; if ({digit1, digit2, digit3} !== 12'h197) begin errors++; $display("[TB] FAIL restart_digits: got %h expected 197", {digit1, digit2, digit3}); end
    checks++; if (capture_cnt !== 8'd2) begin errors++; $display("[TB] FAIL restart_cnt: got %0d expected 2", capture_cnt); end
  endtask

  task automatic test_invalid();
    int p, f, l;
    seg_in = {SEG_4, 7'b1010101, SEG_2};
    run_cycles(10, p, f, l);
    checks++; if (p !== 1) begin errors++; $display("[TB] FAIL inv_pulses: got %0d expected 1", p); end
    checks++; if ({digit1, digit2, digit3} !== 12'h4E2) begin errors++; $display("[TB] FAIL inv_digits: got %h expected 4e2", {digit1, digit2, digit3}); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL inv_err: got %b expected 1", err); end
    seg_in = {SEG_3, SEG_0, SEG_8};
    run_cycles(10, p, f, l);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL inv_clear_err: got %b expected 0", err); end
    checks++; if ({digit1, digit2, digit3} !== 12'h308) begin errors++; $display("[TB] FAIL inv_clear_digits: got %h expected 308", {digit1, digit2, digit3}); end
    checks++; if (capture_cnt !== 8'd4) begin errors++; $display("[TB] FAIL inv_cnt: got %0d expected 4", capture_cnt); end
  endtask

  task automatic test_glitch();
    int p, f, l, p2;
    seg_in = {SEG_4, SEG_0, SEG_8};
    run_cycles(2, p, f, l);
    seg_in = {SEG_3, SEG_0, SEG_8};
    run_cycles(12, p2, f, l);
    checks++; if (p + p2 !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", p + p2); end
    checks++; if (capture_cnt !== 8'd4) begin errors++; $display("[TB] FAIL glitch_cnt: got %0d expected 4", capture_cnt); end
    checks++; if ({digit1, digit2, digit3} !== 12'h308) begin errors++; $display("[TB] FAIL glitch_digits: got %h expected 308", {digit1, digit2, digit3}); end
  endtask

  task automatic test_back_to_back();
    int p, f, l;
    seg_in = {SEG_6, SEG_6, SEG_6};
    run_cycles(5, p, f, l);
    seg_in = {SEG_2, SEG_4, SEG_6};
    run_cycles(15, p, f, l);
    checks++; if (p !== 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", p); end
    checks++; if (f !== 1) begin errors++; $display("[TB] FAIL b2b_first: got edge %0d expected 1", f); end
    checks++; if (l !== 7) begin errors++; $display("[TB] FAIL b2b_second: got edge %0d expected 7", l); end
    checks++; if ({digit1, digit2, digit3} !== 12'h246) begin errors++; $display("[TB] FAIL b2b_digits: got %h expected 246", {digit1, digit2, digit3}); end
    checks++; if (capture_cnt !== 8'd6) begin errors++; $display("[TB] FAIL b2b_cnt: got %0d expected 6", capture_cnt); end
  endtask

  task automatic test_reset_mid_settle();
    int p, f, l;
    seg_in = {SEG_1, SEG_2, SEG_3};
    run_cycles(3, p, f, l);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", valid); end
    checks++; if ({digit1, digit2, digit3} !== 12'hFFF) begin errors++; $display("[TB] FAIL rst_mid_digits: got %h expected fff", {digit1, digit2, digit3}); end
    checks++; if (capture_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_mid_cnt: got %0d expected 0", capture_cnt); end
    run_cycles(10, p, f, l);
    checks++; if (p !== 1 || f !== 6) begin errors++; $display("[TB] FAIL rst_mid_rereport: got %0d pulses at edge %0d expected 1 at 6", p, f); end
    checks++; if ({digit1, digit2, digit3} !== 12'h123) begin errors++; $display("[TB] FAIL rst_mid_digits2: got %h expected 123", {digit1, digit2, digit3}); end
    checks++; if (capture_cnt !== 8'd1) begin errors++; $display("[TB] FAIL rst_mid_cnt2: got %0d expected 1", capture_cnt); end
  endtask

  task automatic test_wrap();
    int p, f, l;
    int total = 0;
    for (int i = 0; i < 255; i++) begin
      seg_in = (i % 2 == 0) ? {SEG_0, SEG_0, SEG_0} : {SEG_1, SEG_1, SEG_1};
      run_cycles(7, p, f, l);
      total += p;
      if (i == 253) begin
        checks++; if (capture_cnt !== 8'd255) begin errors++; $display("[TB] FAIL wrap_max: got %0d expected 255", capture_cnt); end
      end
    end
    checks++; if (total !== 255) begin errors++; $display("[TB] FAIL wrap_pulses: got %0d expected 255", total); end
    checks++; if (capture_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d expected 0", capture_cnt); end
    checks++; if ({digit1, digit2, digit3} !== 12'h000) begin errors++; $display("[TB] FAIL wrap_digits: got %h expected 000", {digit1, digit2, digit3}); end
  endtask

  initial begin
    reset = 1'b1;
    seg_in = '0;
    test_reset();
    test_basic();
    test_restart();
    test_invalid();
    test_glitch();
    test_back_to_back();
    test_reset_mid_settle();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
